text_char_buffer: RTL and testbench
===================================

// Module: text_char_buffer
// PURPOSE
//  Character screen memory feeding the text renderer's ascii_code input. Accepts bytes from
//  the UART receiver (valid/ready), keeps a COLS x ROWS grid of 7-bit codes with a cursor,
//  and returns the code of the 8x16 cell under the current pixel (x,y).
//  The grid covers the renderer's on-region, x 192..447 and y 208..271 (32 cols x 4 rows).
// PARAMETERS
//  COLS       32          characters per row (power of 2)
//  ROWS       4           text rows (power of 2)
//  X0         192         left pixel of grid
//  Y0         208         top pixel of grid
//  BLINK_DIV  25_000_000  clk cycles per cursor blink half-period (CURSOR_BLINK_EN only)
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  rx_data     in   8   incoming byte
//  rx_valid    in   1   rx_data valid
//  rx_ready    out  1   byte accepted when rx_valid & rx_ready
//  x           in   10  current pixel column
//  y           in   10  current pixel row
//  ascii_code  out  7   code of the cell under (x,y), registered
//  cursor_col  out  5   cursor column
//  cursor_row  out  2   cursor row
//  busy        out  1   clear sequence in progress
// BEHAVIOUR
//  Reset values: rx_ready=0, busy=1, cursor=(0,0), ascii_code=0. The FSM enters CLEAR_ALL.
//  Grid RAM contents are not reset.
//  FSM states:
//   IDLE: rx_ready=1; every accepted byte is decoded in that same cycle.
//   CLEAR_ROW: writes 0x20 to one cell per cycle, COLS cycles; rx_ready=0, busy=1.
//   CLEAR_ALL: writes 0x20 to one cell per cycle, COLS*ROWS cycles; rx_ready=0, busy=1.
//   Both clear states return to IDLE.
//  Byte decode:
//   - 0x20..0x7E: write the code at the cursor, then col+1.
//   - Column wrap: if col==COLS-1, col=0 and row advances.
//   - 0x0A or 0x0D: col=0, row advances.
//   - 0x08: if col>0, col-1 and write 0x20 at the new col; at col 0 no effect (never moves up a row).
//   - 0x0C: cursor=(0,0), enter CLEAR_ALL.
//   - Other codes, and any byte with bit7=1: consumed, no effect.
//  Row advance: row=(row+1) mod ROWS, so ROWS-1 wraps to 0. Enter CLEAR_ROW on the new row.
//  Read port: independent of writes.
//   - col=(x-X0)>>3, row=(y-Y0)>>4.
//   - ascii_code is valid 1 clk after x,y; renderer compensates.
//   - Outside the grid, ascii_code=0x00.
//   - Read of a cell written in the same cycle returns old data (read-first).
//  Reset asserted mid-clear or mid-decode aborts it; CLEAR_ALL restarts from cell 0.
//  Address arithmetic: unsigned, in 10 bits, with an explicit range compare before subtracting.
// CONFIGURATION
//  CURSOR_BLINK_EN defined:
//   - Counter toggles a blink phase every BLINK_DIV clks; phase and counter reset to 0.
//   - When phase=1 and the read cell equals the cursor cell, ascii_code=0x5F ('_').
//  Not defined: no counter, BLINK_DIV unused, the cursor cell shows stored data.
// STRUCTURE
//  text_buf_pkg holds:
//   - FSM state enum {IDLE, CLEAR_ROW, CLEAR_ALL}.
//   - Constants ASC_SPACE=0x20, ASC_BS=0x08, ASC_LF=0x0A, ASC_CR=0x0D, ASC_FF=0x0C, ASC_CURSOR=0x5F.
//   - Geometry: CELL_W=8, CELL_H=16.
//  Sub-module text_ram: simple dual-port, COLS*ROWS x 7. Sync write; sync read-first.
// TESTING
//  1 Reset release -> busy=1, rx_ready=0 for 128 clks; then all 128 cells read 0x20, cursor (0,0).
//  2 Send 'H','i' -> cells (0,0)=0x48, (1,0)=0x69, cursor_col=2;
//    x=200,y=208 gives ascii_code=0x69 one clk later; x=100 gives 0x00.
//  3 Send 32 x 'A' -> cursor (0,1); busy for 32 clks; row 1 all 0x20; row 0 all 0x41.
//  4 At col 2 send 0x08 -> col 1, cell (1,row)=0x20; repeat twice -> second 0x08 at col 0 has no effect.
//  5 Cursor at row 3 col 5, send 0x0D -> cursor (0,0); row 0 cleared; rows 1-3 unchanged.
//  6 Send 0x0C with rx_valid held high carrying the next byte 'Z' -> 'Z' not accepted until
//    128 clear clks end; then it is written at (0,0).

Source files
------------

// File: rtl/text_buf_pkg.sv
// Shared types and constants for the text character buffer: FSM states,
// ASCII control codes and character cell geometry.
package text_buf_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ROW = 2'd1,
        CLEAR_ALL = 2'd2
    } state_t;

    localparam logic [6:0] ASC_SPACE  = 7'h20;
    localparam logic [6:0] ASC_TILDE  = 7'h7E;
    localparam logic [6:0] ASC_BS     = 7'h08;
    localparam logic [6:0] ASC_LF     = 7'h0A;
    localparam logic [6:0] ASC_CR     = 7'h0D;
    localparam logic [6:0] ASC_FF     = 7'h0C;
    localparam logic [6:0] ASC_CURSOR = 7'h5F;

    localparam int unsigned CELL_W = 8;
    localparam int unsigned CELL_H = 16;

    // True for codes that are stored in the grid and advance the cursor
    function automatic logic is_printable(input logic [6:0] c);
        return (c >= ASC_SPACE) && (c <= ASC_TILDE);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: synchronous write, synchronous read-first.
// The read register clears to 0 on reset and whenever rd_en is low, so the
// owner can gate out-of-range reads without an extra pipeline stage.
module text_ram #(
    parameter int unsigned AW = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [6:0]    wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [6:0]    rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [6:0] mem [DEPTH];

    // Write port; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port; non-blocking update gives old data on a same-cycle write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= 7'h00;
        end else begin
            rdata <= rd_en ? mem[raddr] : 7'h00;
        end
    end

endmodule

// File: rtl/text_char_buffer.sv
// Character screen memory: decodes UART bytes into a COLS x ROWS grid with a
// cursor and returns the code of the cell under the current pixel (x,y).
// Optional build macro CURSOR_BLINK_EN overlays a blinking '_' on the cursor.
module text_char_buffer
    import text_buf_pkg::*;
#(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 4,
    parameter int unsigned X0   = 192,
    parameter int unsigned Y0   = 208
`ifdef CURSOR_BLINK_EN
    ,
    parameter int unsigned BLINK_DIV = 25_000_000
`endif
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    output logic [6:0]                ascii_code,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy
);

    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned AW  = CW + RW;
    localparam int unsigned CXS = $clog2(CELL_W);
    localparam int unsigned CYS = $clog2(CELL_H);

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [AW-1:0]  clr_q, clr_d;
    logic           busy_q, rx_ready_q;
    logic           accept;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [6:0]     wdata;
    logic           in_grid;
    logic [AW-1:0]  raddr;
    logic [6:0]     ram_q;

    assign accept = rx_valid & rx_ready_q;

    // State, cursor and clear-counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLEAR_ALL;
            col_q      <= '0;
            row_q      <= '0;
            clr_q      <= '0;
            busy_q     <= 1'b1;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            clr_q      <= clr_d;
            busy_q     <= (state_d != IDLE);
            rx_ready_q <= (state_d == IDLE);
        end
    end

    // Byte decode, cursor movement and clear sequencing
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        clr_d   = clr_q;
        we      = 1'b0;
        waddr   = {row_q, col_q};
        wdata   = ASC_SPACE;
        case (state_q)
            IDLE: begin
                if (accept && !rx_data[7]) begin
                    if (is_printable(rx_data[6:0])) begin
                        we    = 1'b1;
                        wdata = rx_data[6:0];
                        if (col_q == CW'(COLS - 1)) begin
                            col_d   = '0;
                            row_d   = row_q + RW'(1);
                            clr_d   = '0;
                            state_d = CLEAR_ROW;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else if (rx_data[6:0] == ASC_LF || rx_data[6:0] == ASC_CR) begin
                        col_d   = '0;
                        row_d   = row_q + RW'(1);
                        clr_d   = '0;
                        state_d = CLEAR_ROW;
                    end else if (rx_data[6:0] == ASC_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - CW'(1);
                            we    = 1'b1;
                            waddr = {row_q, col_q - CW'(1)};
                        end
                    end else if (rx_data[6:0] == ASC_FF) begin
                        col_d   = '0;
                        row_d   = '0;
                        clr_d   = '0;
                        state_d = CLEAR_ALL;
                    end
                end
            end
            CLEAR_ROW: begin
                we    = 1'b1;
                waddr = {row_q, clr_q[CW-1:0]};
                if (clr_q[CW-1:0] == CW'(COLS - 1)) begin
                    clr_d   = '0;
                    state_d = IDLE;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            CLEAR_ALL: begin
                we    = 1'b1;
                waddr = clr_q;
                if (clr_q == AW'(COLS * ROWS - 1)) begin
                    clr_d   = '0;
                    state_d = IDLE;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            default: begin
                state_d = CLEAR_ALL;
                clr_d   = '0;
            end
        endcase
    end

    // Pixel to cell mapping; range checked before the offset subtraction
    always_comb begin
        in_grid = (x >= 10'(X0)) && (x < 10'(X0 + COLS * CELL_W)) &&
                  (y >= 10'(Y0)) && (y < 10'(Y0 + ROWS * CELL_H));
        raddr   = {RW'((y - 10'(Y0)) >> CYS), CW'((x - 10'(X0)) >> CXS)};
    end

    text_ram #(
        .AW(AW)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rd_en  (in_grid),
        .raddr  (raddr),
        .rdata  (ram_q)
    );

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          cursor_hit;

    // Blink half-period counter and phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Flag reads of the cursor cell during the visible blink phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cursor_hit <= 1'b0;
        end else begin
            cursor_hit <= blink_phase && in_grid && (raddr == {row_q, col_q});
        end
    end

    assign ascii_code = cursor_hit ? ASC_CURSOR : ram_q;
`else
    assign ascii_code = ram_q;
`endif

    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;
    assign rx_ready   = rx_ready_q;

endmodule

// File: tb/tb_text_char_buffer.sv
// Randomised bench for text_char_buffer with a scoreboard on the read port:
// reads push their expected code, a monitor pops and compares one clk later.
module tb_text_char_buffer;

    localparam int COLS = 32;
    localparam int ROWS = 4;
    localparam int X0   = 192;
    localparam int Y0   = 208;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] ascii_code;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;
    logic       busy;

    text_char_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .x         (x),
        .y         (y),
        .ascii_code(ascii_code),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: screen contents, cursor, expected clear length
    int grid [COLS*ROWS];
    int mc, mr, exp_clear;
    int total, bad;
    int exp_q [$];
    logic rd_tag;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void blank_row(input int r);
        for (int c = 0; c < COLS; c++) grid[r*COLS + c] = 32'h20;
    endfunction

    function automatic void advance_row();
        mc = 0;
        mr = (mr + 1) % ROWS;
        blank_row(mr);
        exp_clear = COLS;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++) blank_row(r);
        mc = 0;
        mr = 0;
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        exp_clear = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            grid[mr*COLS + mc] = int'(b);
            if (mc == COLS - 1) advance_row();
            else mc++;
        end else if (b == 8'h0A || b == 8'h0D) begin
            advance_row();
        end else if (b == 8'h08) begin
            if (mc > 0) begin
                mc--;
                grid[mr*COLS + mc] = 32'h20;
            end
        end else if (b == 8'h0C) begin
            model_reset();
            exp_clear = COLS * ROWS;
        end
    endfunction

    // scoreboard monitor: one read result per clk while rd_tag is set
    always @(posedge clk) begin
        if (rd_tag) begin
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: read result 0x%0h with no expectation", ascii_code);
            end else begin
                chk("ascii_code", int'(ascii_code), exp_q.pop_front());
            end
        end
    end

    task automatic read_xy(input int xv, input int yv, input int e);
        @(negedge clk);
        x = 10'(xv);
        y = 10'(yv);
        rd_tag = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic read_cell(input int c, input int r);
        read_xy(X0 + c*8 + $urandom_range(0, 7), Y0 + r*16 + $urandom_range(0, 15),
                grid[r*COLS + c]);
    endtask

    task automatic end_reads();
        @(negedge clk);
        rd_tag = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) read_cell(c, r);
        end_reads();
    endtask

    task automatic read_outside();
        int s, xv, yv;
        s  = $urandom_range(0, 3);
        xv = $urandom_range(0, 1023);
        yv = $urandom_range(0, 1023);
        case (s)
            0: xv = $urandom_range(0, X0 - 1);
            1: xv = $urandom_range(X0 + COLS*8, 1023);
            2: yv = $urandom_range(0, Y0 - 1);
            default: yv = $urandom_range(Y0 + ROWS*16, 1023);
        endcase
        read_xy(xv, yv, 0);
    endtask

    // called at a negedge; returns the clks spent waiting for rx_ready
    task automatic send_byte(input logic [7:0] b, input bit hold, output int waited);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: byte 0x%0h waited %0d clks, limit 1000", b, waited);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_apply(b);
        @(negedge clk);
        if (!hold) rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while ((busy || !rx_ready) && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_cursor();
        chk("cursor_col", int'(cursor_col), mc);
        chk("cursor_row", int'(cursor_row), mr);
    endtask

    task automatic send_chk(input logic [7:0] b);
        int w, n;
        send_byte(b, 1'b0, w);
        wait_idle(n);
        chk("clear_len", n, exp_clear);
        check_cursor();
    endtask

    task automatic reset_release_check();
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        reset_n = 1'b1;
        while (busy && n < 2000) begin
            if (rx_ready) rdy_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("reset_busy_len", n, COLS * ROWS);
        chk("ready_during_clear", int'(rdy_seen), 0);
        chk("ready_after_clear", int'(rx_ready), 1);
        model_reset();
        check_cursor();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, n;
        logic [7:0] b;
        total = 0;
        bad = 0;
        rd_tag = 1'b0;
        reset_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        x = 10'd0;
        y = 10'd0;
        mc = 0;
        mr = 0;
        exp_clear = 0;
        repeat (3) @(negedge clk);

        // reset values, then full power-on clear
        chk("reset_busy", int'(busy), 1);
        chk("reset_rx_ready", int'(rx_ready), 0);
        chk("reset_ascii", int'(ascii_code), 0);
        check_cursor();
        reset_release_check();
        read_all();

        // 'H','i' and pixel lookup including edges of the grid
        send_chk(8'h48);
        send_chk(8'h69);
        read_xy(200, 208, 32'h69);
        read_xy(100, 208, 0);
        read_xy(192, 208, 32'h48);
        read_xy(191, 208, 0);
        read_xy(447, 271, grid[ROWS*COLS - 1]);
        read_xy(448, 271, 0);
        read_xy(447, 272, 0);
        read_xy(300, 207, 0);
        end_reads();

        // 32 printable bytes wrap to the next row and clear it
        send_chk(8'h0C);
        for (int i = 0; i < COLS; i++) send_chk(8'h41);
        read_all();

        // backspace, never crossing a row boundary
        send_chk(8'h0C);
        send_chk(8'h71);
        send_chk(8'h0D);
        send_chk(8'h61);
        send_chk(8'h62);
        send_chk(8'h08);
        send_chk(8'h08);
        send_chk(8'h08);
        read_all();

        // CR on the last row wraps to row 0 and clears only row 0
        send_chk(8'h0C);
        for (int r = 0; r < ROWS - 1; r++) begin
            send_chk(8'h41 + 8'(2*r));
            send_chk(8'h42 + 8'(2*r));
            send_chk(8'h0D);
        end
        for (int i = 0; i < 5; i++) send_chk(8'h76 + 8'(i));
        send_chk(8'h0D);
        read_all();

        // form feed with the next byte held on the bus
        send_chk(8'h31);
        send_byte(8'h0C, 1'b1, w);
        send_byte(8'h5A, 1'b0, w);
        chk("ff_hold_wait", w, COLS * ROWS);
        wait_idle(n);
        chk("clear_len", n, exp_clear);
        check_cursor();
        read_cell(0, 0);
        read_cell(1, 0);
        end_reads();

        // randomised byte stream against the model
        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11: b = 8'($urandom_range(32'h20, 32'h7E));
                12: b = 8'h0D;
                13: b = 8'h0A;
                14, 15: b = 8'h08;
                16: b = 8'h0C;
                17: b = 8'($urandom_range(32'h80, 32'hFF));
                18: b = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'($urandom_range(0, 7));
                default: b = ($urandom_range(0, 1) == 0) ? 8'h7E : 8'h20;
            endcase
            send_chk(b);
            if (i % 10 == 9) begin
                for (int k = 0; k < 12; k++)
                    read_cell($urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1));
                read_outside();
                read_outside();
                end_reads();
            end
        end
        read_all();

        // reset in the middle of a row clear restarts the full clear
        send_byte(8'h0D, 1'b0, w);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midclr_busy", int'(busy), 1);
        chk("midclr_rx_ready", int'(rx_ready), 0);
        chk("midclr_ascii", int'(ascii_code), 0);
        chk("midclr_col", int'(cursor_col), 0);
        chk("midclr_row", int'(cursor_row), 0);
        @(negedge clk);
        reset_release_check();
        read_all();
        send_chk(8'h21);
        read_cell(0, 0);
        end_reads();

        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
